// File: rtl/cclimb_input_ctrl.sv
// Input conditioning for the Crazy Climber core.
// PS/2 key events become held key state, which is ORed with both joysticks.
// Opposing directions on each stick are resolved, and coin requests are
// shaped into fixed-width, rate-limited pulses for the core's coin latch.
//
// Coin FSM states
//   state    | meaning
//   ST_IDLE  | coin1 low; waiting for a request rising edge or a pending request
//   ST_PULSE | coin1 high; counting down the pulse width
//   ST_GAP   | coin1 low; counting down the mandatory gap before the next pulse
module cclimb_input_ctrl #(
    parameter logic [23:0] COIN_PULSE   = 24'd2400000,
    parameter logic [23:0] COIN_GAP     = 24'd2400000,
    parameter bit          START_COINS  = 1'b1,
    parameter bit          SOCD_NEUTRAL = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    output logic        l_up,
    output logic        l_down,
    output logic        l_left,
    output logic        l_right,
    output logic        r_up,
    output logic        r_down,
    output logic        r_left,
    output logic        r_right,
    output logic        start1,
    output logic        start2,
    output logic        coin1
);

    // key register slots
    localparam int K_W   = 0;
    localparam int K_A   = 1;
    localparam int K_S   = 2;
    localparam int K_D   = 3;
    localparam int K_UP  = 4;
    localparam int K_DN  = 5;
    localparam int K_LF  = 6;
    localparam int K_RT  = 7;
    localparam int K_F1  = 8;
    localparam int K_1   = 9;
    localparam int K_F2  = 10;
    localparam int K_2   = 11;
    localparam int K_5   = 12;
    localparam int K_6   = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    logic        r_arm;
    logic        r_tog;
    logic [13:0] r_keys;
    logic [10:0] r_joy;

    state_t      r_state;
    logic [23:0] r_cnt;
    logic        r_pend;
    logic        r_req;
    logic        r_coin;

    logic r_l_up, r_l_down, r_l_left, r_l_right;
    logic r_r_up, r_r_down, r_r_left, r_r_right;
    logic r_start1, r_start2;

    logic w_l_up, w_l_down, w_l_left, w_l_right;
    logic w_r_up, w_r_down, w_r_left, w_r_right;
    logic w_start1, w_start2, w_coin_raw;
    logic w_req, w_rise;
    logic w_unused_bits;

    // Extended-code flag and the upper joystick buttons play no part in this map.
    assign w_unused_bits = ^{ps2_key[8], joystick_0[15:11], joystick_1[15:11]};

    // Arm on the first clock after reset (capturing the toggle), then decode each toggle event.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_arm  <= 1'b0;
            r_tog  <= 1'b0;
            r_keys <= '0;
        end else if (!r_arm) begin
            r_arm <= 1'b1;
            r_tog <= ps2_key[10];
        end else if (ps2_key[10] != r_tog) begin
            r_tog <= ps2_key[10];
            case (ps2_key[7:0])
                8'h1D:   r_keys[K_W]  <= ps2_key[9];
                8'h1C:   r_keys[K_A]  <= ps2_key[9];
                8'h1B:   r_keys[K_S]  <= ps2_key[9];
                8'h23:   r_keys[K_D]  <= ps2_key[9];
                8'h75:   r_keys[K_UP] <= ps2_key[9];
                8'h72:   r_keys[K_DN] <= ps2_key[9];
                8'h6B:   r_keys[K_LF] <= ps2_key[9];
                8'h74:   r_keys[K_RT] <= ps2_key[9];
                8'h05:   r_keys[K_F1] <= ps2_key[9];
                8'h16:   r_keys[K_1]  <= ps2_key[9];
                8'h06:   r_keys[K_F2] <= ps2_key[9];
                8'h1E:   r_keys[K_2]  <= ps2_key[9];
                8'h2E:   r_keys[K_5]  <= ps2_key[9];
                8'h36:   r_keys[K_6]  <= ps2_key[9];
                default: ;
            endcase
        end
    end

    // Joysticks are registered first so they line up with the key-register path.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_joy <= '0;
        end else begin
            r_joy <= joystick_0[10:0] | joystick_1[10:0];
        end
    end

    assign w_l_up     = r_keys[K_W]  | r_joy[0];
    assign w_l_down   = r_keys[K_S]  | r_joy[1];
    assign w_l_left   = r_keys[K_A]  | r_joy[2];
    assign w_l_right  = r_keys[K_D]  | r_joy[3];
    assign w_r_up     = r_keys[K_UP] | r_joy[4];
    assign w_r_down   = r_keys[K_DN] | r_joy[5];
    assign w_r_left   = r_keys[K_LF] | r_joy[6];
    assign w_r_right  = r_keys[K_RT] | r_joy[7];
    assign w_start1   = r_keys[K_F1] | r_keys[K_1] | r_joy[8];
    assign w_start2   = r_keys[K_F2] | r_keys[K_2] | r_joy[9];
    assign w_coin_raw = r_keys[K_5]  | r_keys[K_6] | r_joy[10];

    assign w_req  = w_coin_raw | (START_COINS & (w_start1 | w_start2));
    assign w_rise = w_req & ~r_req;

    // Register stick outputs, neutralising opposing pairs when enabled.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_l_up    <= 1'b0;
            r_l_down  <= 1'b0;
            r_l_left  <= 1'b0;
            r_l_right <= 1'b0;
            r_r_up    <= 1'b0;
            r_r_down  <= 1'b0;
            r_r_left  <= 1'b0;
            r_r_right <= 1'b0;
            r_start1  <= 1'b0;
            r_start2  <= 1'b0;
        end else begin
            r_l_up    <= w_l_up    & ~(SOCD_NEUTRAL & w_l_down);
            r_l_down  <= w_l_down  & ~(SOCD_NEUTRAL & w_l_up);
            r_l_left  <= w_l_left  & ~(SOCD_NEUTRAL & w_l_right);
            r_l_right <= w_l_right & ~(SOCD_NEUTRAL & w_l_left);
            r_r_up    <= w_r_up    & ~(SOCD_NEUTRAL & w_r_down);
            r_r_down  <= w_r_down  & ~(SOCD_NEUTRAL & w_r_up);
            r_r_left  <= w_r_left  & ~(SOCD_NEUTRAL & w_r_right);
            r_r_right <= w_r_right & ~(SOCD_NEUTRAL & w_r_left);
            r_start1  <= w_start1;
            r_start2  <= w_start2;
        end
    end

    // Coin shaper: one pulse per request edge, with a single-deep pending slot.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_req   <= 1'b0;
            r_coin  <= 1'b0;
        end else begin
            r_req <= w_req;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise || r_pend) begin
                        r_state <= ST_PULSE;
                        r_coin  <= 1'b1;
                        r_cnt   <= COIN_PULSE - 24'd1;
                        r_pend  <= 1'b0;
                    end
                end
                ST_PULSE: begin
                    if (w_rise) r_pend <= 1'b1;
                    if (r_cnt == 24'd0) begin
                        r_state <= ST_GAP;
                        r_coin  <= 1'b0;
                        r_cnt   <= COIN_GAP - 24'd1;
                    end else begin
                        r_cnt <= r_cnt - 24'd1;
                    end
                end
                ST_GAP: begin
                    if (w_rise) r_pend <= 1'b1;
                    if (r_cnt == 24'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 24'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_coin  <= 1'b0;
                end
            endcase
        end
    end

    assign l_up    = r_l_up;
    assign l_down  = r_l_down;
    assign l_left  = r_l_left;
    assign l_right = r_l_right;
    assign r_up    = r_r_up;
    assign r_down  = r_r_down;
    assign r_left  = r_r_left;
    assign r_right = r_r_right;
    assign start1  = r_start1;
    assign start2  = r_start2;
    assign coin1   = r_coin;

endmodule

// File: tb/tb_cclimb_input_ctrl.sv
// Directed bench: two instances share stimulus, one with start-coins and
// SOCD neutral enabled, the other with both disabled.
module tb_cclimb_input_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] ps2_key = '0;
    logic [15:0] joystick_0 = '0;
    logic [15:0] joystick_1 = '0;

    logic a_lu, a_ld, a_ll, a_lr, a_ru, a_rd, a_rl, a_rr, a_s1, a_s2, a_coin;
    logic b_lu, b_ld, b_ll, b_lr, b_ru, b_rd, b_rl, b_rr, b_s1, b_s2, b_coin;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk_sys = ~clk_sys;

    cclimb_input_ctrl #(
        .COIN_PULSE(24'd4), .COIN_GAP(24'd3), .START_COINS(1'b1), .SOCD_NEUTRAL(1'b1)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1),
        .l_up(a_lu), .l_down(a_ld), .l_left(a_ll), .l_right(a_lr),
        .r_up(a_ru), .r_down(a_rd), .r_left(a_rl), .r_right(a_rr),
        .start1(a_s1), .start2(a_s2), .coin1(a_coin)
    );

    cclimb_input_ctrl #(
        .COIN_PULSE(24'd4), .COIN_GAP(24'd3), .START_COINS(1'b0), .SOCD_NEUTRAL(1'b0)
    ) dut_b (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1),
        .l_up(b_lu), .l_down(b_ld), .l_left(b_ll), .l_right(b_lr),
        .r_up(b_ru), .r_down(b_rd), .r_left(b_rl), .r_right(b_rr),
        .start1(b_s1), .start2(b_s2), .coin1(b_coin)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts coin1 high cycles on the first instance over n clocks.
    task automatic measure(input int n, output int first, output int cnt);
        first = -1;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (a_coin) begin
                if (first < 0) first = i;
                cnt++;
            end
        end
    endtask

    initial begin
        int first_hi;
        int n_hi;
        int n_hi_b;

        // reset state, with a held key pressed before arming
        ps2_key = {1'b1, 1'b1, 9'h01D};
        tick();
        tick();
        check("rst_coin", {31'd0, a_coin}, 32'd0);
        check("rst_lstick", {28'd0, a_lu, a_ld, a_ll, a_lr}, 32'd0);
        check("rst_start", {30'd0, a_s1, a_s2}, 32'd0);
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        check("armed_no_lup", {31'd0, a_lu}, 32'd0);

        // W press event, then release
        ps2_key = {1'b0, 1'b1, 9'h01D};
        tick();
        check("w_press_lat1", {31'd0, a_lu}, 32'd0);
        tick();
        check("w_press", {31'd0, a_lu}, 32'd1);
        check("w_no_coin", {31'd0, a_coin}, 32'd0);
        ps2_key = {1'b1, 1'b0, 9'h01D};
        tick();
        tick();
        check("w_release", {31'd0, a_lu}, 32'd0);

        // extended up-arrow drives right stick
        ps2_key = {1'b0, 1'b1, 9'h175};
        tick();
        tick();
        check("arrow_up", {28'd0, a_ru, a_rd, a_rl, a_rr}, 32'h8);
        ps2_key = {1'b1, 1'b0, 9'h175};
        tick();
        tick();
        check("arrow_rel", {31'd0, a_ru}, 32'd0);

        // SOCD: all four left directions, right stick R from joystick_1
        joystick_0 = 16'h000F;
        joystick_1 = 16'h0080;
        tick();
        tick();
        check("socd_a_left", {28'd0, a_lu, a_ld, a_ll, a_lr}, 32'h0);
        check("socd_b_left", {28'd0, b_lu, b_ld, b_ll, b_lr}, 32'hF);
        check("socd_a_right", {28'd0, a_ru, a_rd, a_rl, a_rr}, 32'h1);
        check("socd_b_right", {28'd0, b_ru, b_rd, b_rl, b_rr}, 32'h1);
        joystick_0 = 16'h0005;
        joystick_1 = 16'h0000;
        tick();
        tick();
        check("diag_a_left", {28'd0, a_lu, a_ld, a_ll, a_lr}, 32'hA);
        joystick_0 = 16'h0000;
        tick();
        tick();

        // held coin: exactly one 4-cycle pulse
        joystick_0 = 16'h0400;
        tick();
        check("held_lat", {31'd0, a_coin}, 32'd0);
        measure(49, first_hi, n_hi);
        check("held_first", first_hi, 32'd0);
        check("held_width", n_hi, 32'd4);
        joystick_0 = 16'h0000;
        for (int i = 0; i < 10; i++) tick();

        // request edges at t=0,2,5: pulses at t=1..4 and 9..12, third dropped
        for (int t = 0; t < 20; t++) begin
            joystick_0 = (t == 0 || t == 2 || t == 5) ? 16'h0400 : 16'h0000;
            tick();
            check($sformatf("multi_t%0d", t), {31'd0, a_coin},
                  ((t >= 1 && t <= 4) || (t >= 9 && t <= 12)) ? 32'd1 : 32'd0);
        end
        joystick_0 = 16'h0000;
        for (int i = 0; i < 5; i++) tick();

        // start key coins only when START_COINS=1
        ps2_key = {1'b0, 1'b1, 9'h016};
        tick();
        tick();
        check("start_a", {31'd0, a_s1}, 32'd1);
        check("start_b", {31'd0, b_s1}, 32'd1);
        check("start_coin_a", {31'd0, a_coin}, 32'd1);
        check("start_coin_b", {31'd0, b_coin}, 32'd0);
        n_hi = 0;
        n_hi_b = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a_coin) n_hi++;
            if (b_coin) n_hi_b++;
        end
        check("start_rest_a", n_hi, 32'd3);
        check("start_rest_b", n_hi_b, 32'd0);
        ps2_key = {1'b1, 1'b0, 9'h016};
        for (int i = 0; i < 5; i++) tick();
        check("start_rel", {31'd0, a_s1}, 32'd0);

        // reset in mid-pulse
        joystick_0 = 16'h0400;
        tick();
        tick();
        check("mid_pulse_hi", {31'd0, a_coin}, 32'd1);
        tick();
        joystick_0 = 16'h0000;
        reset_n = 1'b0;
        #1;
        check("async_drop", {31'd0, a_coin}, 32'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("pend_lost", {31'd0, a_coin}, 32'd0);
        joystick_0 = 16'h0400;
        tick();
        measure(12, first_hi, n_hi);
        check("post_rst_first", first_hi, 32'd0);
        check("post_rst_width", n_hi, 32'd4);
        joystick_0 = 16'h0000;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
